// File: rtl/rv_lsu.sv
// Load/store unit: one core access becomes one held memory request; done pulses one cycle after rvalid/misalign/timeout.
// Latency: misaligned done after acceptance edge; otherwise done the cycle after rvalid. Core must hold while busy.
module rv_lsu #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_size_i,
    input  logic        lsu_unsigned_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_busy_o,
    output logic        lsu_done_o,
    output logic        lsu_err_o,
    output logic [31:0] lsu_rdata_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [1:0]    off_q, off_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;

    logic          aligned;
    logic [3:0]    store_be;
    logic [31:0]   store_wdata;
    logic [7:0]    load_byte;
    logic [15:0]   load_half;
    logic [31:0]   load_data;

    always_comb begin
        case (lsu_size_i)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~lsu_addr_i[0];
            2'b10:   aligned = (lsu_addr_i[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    // Store data is replicated across all lanes so the enabled lane always carries the value.
    always_comb begin
        case (lsu_size_i)
            2'b00: begin
                store_be    = 4'b0001 << lsu_addr_i[1:0];
                store_wdata = {4{lsu_wdata_i[7:0]}};
            end
            2'b01: begin
                store_be    = 4'b0011 << lsu_addr_i[1:0];
                store_wdata = {2{lsu_wdata_i[15:0]}};
            end
            default: begin
                store_be    = 4'b1111;
                store_wdata = lsu_wdata_i;
            end
        endcase
    end

    always_comb begin
        load_byte = data_rdata_i[{off_q, 3'b000} +: 8];
        load_half = off_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
        case (size_q)
            2'b00:   load_data = {{24{~uns_q & load_byte[7]}}, load_byte};
            2'b01:   load_data = {{16{~uns_q & load_half[15]}}, load_half};
            default: load_data = data_rdata_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        req_d   = req_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            IDLE: begin
                if (lsu_req_i) begin
                    busy_d = 1'b1;
                    if (aligned) begin
                        size_d  = lsu_size_i;
                        uns_d   = lsu_unsigned_i;
                        off_d   = lsu_addr_i[1:0];
                        cnt_d   = '0;
                        req_d   = 1'b1;
                        we_d    = lsu_we_i;
                        be_d    = lsu_we_i ? store_be : 4'b1111;
                        addr_d  = {lsu_addr_i[31:2], 2'b00};
                        wdata_d = store_wdata;
                        state_d = WAIT;
                    end else begin
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = DONE;
                    end
                end
            end
            WAIT: begin
                // rvalid wins over a timeout landing in the same cycle.
                if (data_rvalid_i) begin
                    req_d   = 1'b0;
                    rdata_d = we_q ? 32'd0 : load_data;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    req_d   = 1'b0;
                    rdata_d = '0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                req_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                req_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            state_q <= IDLE;
            size_q  <= '0;
            uns_q   <= 1'b0;
            off_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            req_q   <= req_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign lsu_busy_o   = busy_q;
    assign lsu_done_o   = done_q;
    assign lsu_err_o    = err_q;
    assign lsu_rdata_o  = rdata_q;
    assign data_req_o   = req_q;
    assign data_we_o    = we_q;
    assign data_be_o    = be_q;
    assign data_addr_o  = addr_q;
    assign data_wdata_o = wdata_q;

endmodule

// File: tb/tb_rv_lsu.sv
// Bench for rv_lsu: byte-array reference memory plus a latency-pipe slave; per-cycle compare of the request/done protocol.
module tb_rv_lsu;
    localparam int TO      = 8;
    localparam int MEM_LAT = 5;

    logic        clk = 1'b0;
    logic        arstn;
    logic        lsu_req, lsu_we, lsu_unsigned;
    logic [1:0]  lsu_size;
    logic [31:0] lsu_addr, lsu_wdata;
    logic        lsu_busy, lsu_done, lsu_err;
    logic [31:0] lsu_rdata;
    logic        data_req, data_we, data_rvalid;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata, data_rdata;

    always #5 clk = ~clk;

    rv_lsu #(.TIMEOUT(TO)) dut (
        .clk_i(clk), .arstn_i(arstn),
        .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_size_i(lsu_size),
        .lsu_unsigned_i(lsu_unsigned), .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
        .lsu_busy_o(lsu_busy), .lsu_done_o(lsu_done), .lsu_err_o(lsu_err), .lsu_rdata_o(lsu_rdata),
        .data_req_o(data_req), .data_we_o(data_we), .data_be_o(data_be),
        .data_addr_o(data_addr), .data_wdata_o(data_wdata),
        .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata)
    );

    // Slave memory: answers after a fixed pipe, pipe flushed whenever req is low.
    logic [31:0] mem [0:255];
    logic [3:0]  sh;
    bit          rvalid_en = 1;
    assign data_rvalid = rvalid_en & sh[3];
    assign data_rdata  = mem[data_addr[9:2]];

    always @(posedge clk) begin
        if (!data_req) sh <= '0;
        else           sh <= {sh[2:0], 1'b1};
        if (data_req && data_we)
            for (int i = 0; i < 4; i++)
                if (data_be[i]) mem[data_addr[9:2]][8*i +: 8] <= data_wdata[8*i +: 8];
    end

    // Reference model: flat byte memory.
    logic [7:0] ref_b [0:1023];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
        end
    endtask

    // Expectations for the transaction in flight.
    bit          en = 0, manual = 1, live = 0, done_seen = 0;
    int          k = 0;
    bit          exp_access, exp_we, exp_err;
    int          exp_n;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [31:0] cap_rdata, cap_wd;
    logic [3:0]  cap_be;
    logic        cap_err;
    int          cap_n;

    always @(negedge clk) begin
        if (en) begin
            if (live) begin
                if (k == 0) begin
                    chk("pre_busy", lsu_busy, 0);
                    chk("pre_req", data_req, 0);
                end else if (!done_seen) begin
                    chk("done_timing", lsu_done, (k - 1) == exp_n);
                    chk("busy", lsu_busy, 1);
                    chk("req", data_req, exp_access && (k - 1) < exp_n);
                    if (data_req) begin
                        chk("we", data_we, exp_we);
                        chk("be", data_be, exp_be);
                        chk("addr", data_addr, exp_addr);
                        if (exp_we) chk("wdata", data_wdata, exp_wdata);
                        if (k == 1) begin
                            cap_be = data_be;
                            cap_wd = data_wdata;
                        end
                    end
                    if (lsu_done) begin
                        chk("err", lsu_err, exp_err);
                        chk("rdata", lsu_rdata, exp_rdata);
                        cap_rdata = lsu_rdata;
                        cap_err   = lsu_err;
                        cap_n     = k - 1;
                        done_seen = 1;
                    end
                end else begin
                    chk("post_done", lsu_done, 0);
                    chk("post_busy", lsu_busy, 0);
                    chk("post_req", data_req, 0);
                    live = 0;
                end
                k++;
            end else begin
                chk("quiet_done", lsu_done, 0);
                if (!manual) chk("quiet_req", data_req, 0);
            end
        end
    end

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int nb, input bit uns);
        logic [31:0] v = 0;
        for (int j = 0; j < nb; j++) v = v | (32'(ref_b[a[9:0] + j]) << (8 * j));
        if (nb < 4 && !uns && v >= (32'd1 << (8 * nb - 1))) v = v - (32'd1 << (8 * nb));
        return v;
    endfunction

    task automatic poke(input logic [31:0] a, input logic [31:0] v);
        mem[a[9:2]] = v;
        for (int j = 0; j < 4; j++) ref_b[a[9:0] + j] = v[8*j +: 8];
    endtask

    task automatic do_op(input bit we, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd);
        int nb;
        @(posedge clk); #1;
        nb         = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        exp_access = (sz != 2'd3) && (a % nb == 0);
        exp_we     = we;
        exp_addr   = a & 32'hFFFF_FFFC;
        exp_n      = !exp_access ? 0 : (rvalid_en ? MEM_LAT : TO);
        exp_err    = !exp_access || !rvalid_en;
        exp_be     = 4'hF;
        exp_wdata  = 0;
        if (we) begin
            exp_be = 0;
            for (int j = 0; j < nb; j++) exp_be[(a + j) % 4] = 1'b1;
            for (int l = 0; l < 4; l++) exp_wdata[8*l +: 8] = wd[8*(l % nb) +: 8];
        end
        exp_rdata = (!we && !exp_err) ? ref_load(a, nb, uns) : 32'd0;
        cap_rdata = 32'hXXXX_XXXX; cap_err = 1'bx; cap_n = -1; cap_be = 4'hX; cap_wd = 32'hXXXX_XXXX;
        lsu_we = we; lsu_size = sz; lsu_unsigned = uns; lsu_addr = a; lsu_wdata = wd;
        lsu_req = 1; k = 0; done_seen = 0; live = 1;
        @(posedge clk); #1;
        lsu_req = 0;
        for (int i = 0; i < 200 && live; i++) @(posedge clk);
        chk("no_hang", live, 0);
        live = 0;
        if (we && !exp_err)
            for (int j = 0; j < nb; j++) ref_b[a[9:0] + j] = wd[8*j +: 8];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) poke(32'(i * 4), 32'd0);
        poke(32'h100, 32'hDEADBEEF);
        poke(32'h200, 32'h8001_7FFF);
        arstn = 0; lsu_req = 0; lsu_we = 0; lsu_size = 0; lsu_unsigned = 0; lsu_addr = 0; lsu_wdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", data_req, 0);
        chk("rst_done", lsu_done, 0);
        chk("rst_err", lsu_err, 0);
        chk("rst_busy", lsu_busy, 0);
        chk("rst_rdata", lsu_rdata, 0);
        chk("rst_be", data_be, 0);
        chk("rst_addr", data_addr, 0);
        arstn = 1; en = 1; manual = 0;

        do_op(0, 2'd2, 0, 32'h100, 0);
        chk("lw_rdata", cap_rdata, 32'hDEADBEEF); chk("lw_err", cap_err, 0); chk("lw_lat", cap_n, 5);

        do_op(1, 2'd0, 0, 32'h103, 32'h0000_00A5);
        chk("sb_be", cap_be, 4'b1000); chk("sb_wd", cap_wd, 32'hA5A5A5A5); chk("sb_err", cap_err, 0);
        do_op(0, 2'd0, 1, 32'h103, 0); chk("lbu", cap_rdata, 32'h0000_00A5);
        do_op(0, 2'd0, 0, 32'h103, 0); chk("lb", cap_rdata, 32'hFFFF_FFA5);

        do_op(0, 2'd1, 0, 32'h202, 0); chk("lh_hi", cap_rdata, 32'hFFFF_8001);
        do_op(0, 2'd1, 1, 32'h202, 0); chk("lhu_hi", cap_rdata, 32'h0000_8001);
        do_op(0, 2'd1, 0, 32'h200, 0); chk("lh_lo", cap_rdata, 32'h0000_7FFF);

        do_op(0, 2'd2, 0, 32'h101, 0); chk("lw_mis_err", cap_err, 1); chk("lw_mis_lat", cap_n, 0);
        do_op(1, 2'd1, 0, 32'h103, 32'h1234); chk("sh_mis_err", cap_err, 1); chk("sh_mis_lat", cap_n, 0);
        do_op(0, 2'd3, 0, 32'h100, 0); chk("sz11_err", cap_err, 1);

        do_op(1, 2'd1, 0, 32'h206, 32'hCAFE_1234);
        chk("sh_be", cap_be, 4'b1100); chk("sh_wd", cap_wd, 32'h1234_1234);
        do_op(0, 2'd2, 0, 32'h204, 0); chk("lw_after_sh", cap_rdata, 32'h1234_0000);
        do_op(1, 2'd2, 0, 32'h300, 32'h1122_3344);
        do_op(0, 2'd0, 0, 32'h301, 0); chk("lb_after_sw", cap_rdata, 32'h0000_0033);

        rvalid_en = 0;
        do_op(0, 2'd2, 0, 32'h100, 0);
        chk("to_err", cap_err, 1); chk("to_lat", cap_n, 8); chk("to_rdata", cap_rdata, 0);
        rvalid_en = 1;
        do_op(0, 2'd2, 0, 32'h200, 0); chk("after_to", cap_rdata, 32'h8001_7FFF);

        manual = 1;
        @(posedge clk); #1;
        lsu_we = 0; lsu_size = 2'd2; lsu_unsigned = 0; lsu_addr = 32'h100; lsu_req = 1;
        @(posedge clk); #1; lsu_req = 0;
        @(posedge clk); #1; arstn = 0;
        @(negedge clk); chk("mid_req_before", data_req, 1);
        @(posedge clk); #1; arstn = 1;
        @(negedge clk);
        chk("mid_req_after", data_req, 0); chk("mid_busy_after", lsu_busy, 0); chk("mid_done_after", lsu_done, 0);
        repeat (8) @(posedge clk);
        manual = 0;
        do_op(0, 2'd2, 0, 32'h100, 0);
        chk("after_rst", cap_rdata, 32'hA5AD_BEEF); chk("after_rst_err", cap_err, 0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
